arbiter_4_rr_sched: RTL and testbench

Clocked four-requester round-robin scheduler that shares one exclusive resource. It is the synchronous successor to the two-input NAND-latch mutex.
- Grants are one-hot, registered and never overlap.
- Grants are break-before-make, with a guaranteed idle cycle between owners.
- Sits between requesting agents and the shared resource. Owners hold access until they release, with no preemption; an optional watchdog can force revocation.

---
 rtl/arb_pkg.sv | 25 ++
 rtl/rr_priority_pick.sv | 28 ++
 rtl/arbiter_4_rr_sched.sv | 131 +++++++++++++
 tb/tb_arbiter_4_rr_sched.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin scheduler family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

    localparam int N_REQ    = 4;
    localparam int PTR_W    = 2;
    localparam int HOLD_MAX = 15;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } arb_state_t;

    // Rotate priority to the requester after the given owner, wrapping at N_REQ.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] id);
        if (int'(id) == N_REQ - 1) begin
            return '0;
        end
        return id + PTR_W'(1);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Circular priority encoder: first set request searching from ptr upward, wrapping.
// Latency: purely combinational.
// Backpressure: none; the winner is valid whenever any request is set.
module rr_priority_pick
    import arb_pkg::*;
(
    input  logic [N_REQ-1:0] req_i,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] idx_o,
    output logic             vld_o
);

    logic [PTR_W-1:0] cand;

    // Walk offsets from farthest to nearest so the nearest set bit overwrites last.
    always_comb begin
        idx_o = ptr_i;
        vld_o = |req_i;
        cand  = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            cand = PTR_W'((int'(ptr_i) + off) % N_REQ);
            if (req_i[cand]) begin
                idx_o = cand;
            end
        end
    end

endmodule

// File: rtl/arbiter_4_rr_sched.sv
// Four-way round-robin owner scheduler, break-before-make with a one-cycle GAP; ARB_TIMEOUT_EN adds a hold watchdog.
// Latency: REQ->GNT one cycle from IDLE; release->new grant two dead cycles.
// Backpressure: owner keeps the grant until it drops its request (or the watchdog revokes); others wait.
module arbiter_4_rr_sched
    import arb_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic [N_REQ-1:0] req_i,
    output logic [N_REQ-1:0] gnt_o,
    output logic [PTR_W-1:0] gnt_id_o,
    output logic             busy_o,
    output logic             timeout_o
);

    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    arb_state_t       state_q;
    logic [PTR_W-1:0] ptr_q;
    logic [N_REQ-1:0] gnt_q;
    logic [PTR_W-1:0] gnt_id_q;
    logic             busy_q;
    logic [PTR_W-1:0] pick_idx;
    logic             pick_vld;

    rr_priority_pick u_pick (
        .req_i (req_i),
        .ptr_i (ptr_q),
        .idx_o (pick_idx),
        .vld_o (pick_vld)
    );

`ifdef ARB_TIMEOUT_EN
    logic [CNT_W-1:0] cnt_q;
    logic             timeout_q;

    // Scheduler FSM with watchdog: registered grant, pointer, hold counter and revoke pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            gnt_q     <= '0;
            gnt_id_q  <= '0;
            busy_q    <= 1'b0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q    <= ONE_HOT0 << pick_idx;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        cnt_q    <= '0;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    // A release wins over a coincident timeout, so no pulse then.
                    if (!req_i[gnt_id_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= next_ptr(gnt_id_q);
                        state_q <= GAP;
                    end else if (cnt_q == CNT_W'(HOLD_MAX - 1)) begin
                        gnt_q     <= '0;
                        busy_q    <= 1'b0;
                        timeout_q <= 1'b1;
                        ptr_q     <= next_ptr(gnt_id_q);
                        state_q   <= GAP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign timeout_o = timeout_q;
`else
    // Scheduler FSM: registered grant and rotating pointer, unbounded hold.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        gnt_q    <= ONE_HOT0 << pick_idx;
                        gnt_id_q <= pick_idx;
                        busy_q   <= 1'b1;
                        state_q  <= GRANT;
                    end
                end
                GRANT: begin
                    if (!req_i[gnt_id_q]) begin
                        gnt_q   <= '0;
                        busy_q  <= 1'b0;
                        ptr_q   <= next_ptr(gnt_id_q);
                        state_q <= GAP;
                    end
                end
                GAP: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign timeout_o = 1'b0;
`endif

    assign gnt_o    = gnt_q;
    assign gnt_id_o = gnt_id_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_arbiter_4_rr_sched.sv
// Directed bench for arbiter_4_rr_sched; define ARB_TIMEOUT_EN to also exercise the watchdog.
// Latency: n/a.
// Backpressure: n/a.
module tb_arbiter_4_rr_sched;

    logic       clk;
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int errors = 0;

    arbiter_4_rr_sched dut (
        .clk_i     (clk),
        .rst_n_i   (rst_n),
        .req_i     (req),
        .gnt_o     (gnt),
        .gnt_id_o  (gnt_id),
        .busy_o    (busy),
        .timeout_o (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, sample 1ns later, and check the always-true invariants.
    task automatic tick();
        @(posedge clk);
        #1;
        chk("onehot0", 32'($onehot0(gnt)), 32'd1);
        chk("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
`ifndef ARB_TIMEOUT_EN
        chk("timeout_tied0", 32'(timeout), 32'd0);
`endif
    endtask

    task automatic step(input string tag, input logic [3:0] eg, input logic eb, input logic [1:0] eid);
        tick();
        chk({tag, "_gnt"}, 32'(gnt), 32'(eg));
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_id"}, 32'(gnt_id), 32'(eid));
    endtask

    // Owner holds three cycles total, drops request one cycle, restores it; next owner appears after two dead cycles.
    task automatic serve(input logic [1:0] id, input logic [1:0] nxt);
        logic [3:0] mask;
        mask = 4'b0001 << id;
        step("hold1", mask, 1'b1, id);
        step("hold2", mask, 1'b1, id);
        req = req & ~mask;
        step("release", 4'b0000, 1'b0, id);
        req = req | mask;
        step("gap", 4'b0000, 1'b0, id);
        step("handoff", 4'b0001 << nxt, 1'b1, nxt);
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 4'b1111;

        // Reset held with all requests present.
        tick();
        tick();
        step("reset", 4'b0000, 1'b0, 2'd0);
        chk("reset_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        step("first_grant", 4'b0001, 1'b1, 2'd0);

        // Full contention rotation 0,1,2,3,0.
        serve(2'd0, 2'd1);
        serve(2'd1, 2'd2);
        serve(2'd2, 2'd3);
        serve(2'd3, 2'd0);

        // Sparse rotation: owner 0 hands to 1, 1 releases leaving ptr=2, then only 0 and 1 request.
        req = 4'b1110;
        step("sp_rel0", 4'b0000, 1'b0, 2'd0);
        step("sp_gap0", 4'b0000, 1'b0, 2'd0);
        step("sp_gnt1", 4'b0010, 1'b1, 2'd1);
        req = 4'b0000;
        step("sp_rel1", 4'b0000, 1'b0, 2'd1);
        req = 4'b0011;
        step("sp_gap1", 4'b0000, 1'b0, 2'd1);
        step("sp_wrap0", 4'b0001, 1'b1, 2'd0);

        // No preemption: requester 2 owns while 3 and 0 push for 20 cycles.
        req = 4'b0100;
        step("np_rel0", 4'b0000, 1'b0, 2'd0);
        step("np_gap", 4'b0000, 1'b0, 2'd0);
        step("np_gnt2", 4'b0100, 1'b1, 2'd2);
        req = 4'b1101;
        for (int i = 0; i < 20; i++) begin
            step("np_hold", 4'b0100, 1'b1, 2'd2);
        end
        req = 4'b1001;
        step("np_rel2", 4'b0000, 1'b0, 2'd2);
        step("np_gap2", 4'b0000, 1'b0, 2'd2);
        step("np_gnt3", 4'b1000, 1'b1, 2'd3);

        // Mid-grant reset while 3 owns; regrant to 3 right after release of reset.
        req   = 4'b1000;
        rst_n = 1'b0;
        step("mr_reset", 4'b0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        step("mr_regrant3", 4'b1000, 1'b1, 2'd3);

        // Reset again with 1 and 3 requesting: pointer back at 0 makes 1 win.
        req   = 4'b1010;
        rst_n = 1'b0;
        step("pr_reset", 4'b0000, 1'b0, 2'd0);
        rst_n = 1'b1;
        step("pr_gnt1", 4'b0010, 1'b1, 2'd1);

        // A request present only at the GAP edge is never granted.
        req = 4'b0000;
        step("pulse_rel", 4'b0000, 1'b0, 2'd1);
        req = 4'b0100;
        step("pulse_gap", 4'b0000, 1'b0, 2'd1);
        req = 4'b0000;
        step("pulse_idle", 4'b0000, 1'b0, 2'd1);
        step("pulse_idle2", 4'b0000, 1'b0, 2'd1);

`ifdef ARB_TIMEOUT_EN
        // Watchdog: requester 1 alone holds forever (ptr=2, wraps to 1).
        req = 4'b0010;
        step("to_gnt1", 4'b0010, 1'b1, 2'd1);
        for (int i = 0; i < 14; i++) begin
            step("to_hold", 4'b0010, 1'b1, 2'd1);
            chk("to_hold_pulse", 32'(timeout), 32'd0);
        end
        step("to_revoke", 4'b0000, 1'b0, 2'd1);
        chk("to_pulse", 32'(timeout), 32'd1);
        step("to_gap", 4'b0000, 1'b0, 2'd1);
        chk("to_pulse_end", 32'(timeout), 32'd0);
        step("to_regrant1", 4'b0010, 1'b1, 2'd1);
        req = 4'b0110;
        for (int i = 0; i < 14; i++) begin
            step("to_hold2", 4'b0010, 1'b1, 2'd1);
        end
        step("to_revoke2", 4'b0000, 1'b0, 2'd1);
        chk("to_pulse2", 32'(timeout), 32'd1);
        step("to_gap2", 4'b0000, 1'b0, 2'd1);
        step("to_gnt2", 4'b0100, 1'b1, 2'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
